// File: rtl/adc_scan_sequencer.sv
// Self-timed round-robin ADC scan sequencer: generates a sample tick, walks NCH channels through
// the spi2adc handshake with a timeout, applies a saturating gain and emits tagged samples.
module adc_scan_sequencer #(
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned NCH        = 2,
  parameter int unsigned DW         = 10,
  parameter int unsigned GW         = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic          sysclk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [GW-1:0] gain,
  input  logic          clr_flags,
  output logic          adc_start,
  output logic [2:0]    adc_channel,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  output logic [DW-1:0] sample_out,
  output logic [2:0]    sample_ch,
  output logic          sample_valid,
  output logic          scan_done,
  output logic          overrun,
  output logic          timeout_err
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = DW + GW;

  localparam logic [CW-1:0] CntLast     = CW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
  localparam logic [2:0]    ChLast      = 3'(NCH - 1);
  localparam logic [DW-1:0] SatMax      = '1;

  typedef enum logic [2:0] {StIdle, StStart, StWait, StScale, StEmit} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] sample_q, sample_d;
  logic [2:0]    sch_q, sch_d;
  logic          overrun_q, overrun_d;
  logic          terr_q, terr_d;
  logic          tick;
  logic [PW-1:0] product, shifted;
  logic [DW-1:0] scaled;

  // Counter free-runs independent of enable so the scan rate never drifts.
  assign tick  = (cnt_q == CntLast);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  // Gain is fixed-point with unity at 2^(GW-1); anything above full scale clamps.
  always_comb begin
    product = {{GW{1'b0}}, data_q} * {{DW{1'b0}}, gain};
    shifted = product >> (GW - 1);
    scaled  = (|shifted[PW-1:DW]) ? SatMax : shifted[DW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    sample_d  = sample_q;
    sch_d     = sch_q;
    overrun_d = overrun_q;
    terr_d    = terr_q;

    // Clear first so a coincident set condition below wins.
    if (clr_flags) begin
      overrun_d = 1'b0;
      terr_d    = 1'b0;
    end
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (tick && enable) begin
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // Valid takes priority over a timeout landing on the same cycle.
        if (adc_valid) begin
          data_d  = adc_data;
          state_d = StScale;
        end else if (tcnt_q == TimeoutLast) begin
          data_d  = '0;
          terr_d  = 1'b1;
          state_d = StScale;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StScale: begin
        sample_d = scaled;
        sch_d    = idx_q;
        state_d  = StEmit;
      end
      StEmit: begin
        if (idx_q == ChLast) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StStart;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      sample_q  <= '0;
      sch_q     <= '0;
      overrun_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      sample_q  <= sample_d;
      sch_q     <= sch_d;
      overrun_q <= overrun_d;
      terr_q    <= terr_d;
    end
  end

  assign adc_start    = (state_q == StStart);
  assign adc_channel  = idx_q;
  assign sample_out   = sample_q;
  assign sample_ch    = sch_q;
  assign sample_valid = (state_q == StEmit);
  assign scan_done    = (state_q == StEmit) && (idx_q == ChLast);
  assign overrun      = overrun_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural spi2adc model, scoreboard of expected tagged samples,
// gain vector table and hand-written timeout/overrun/reset/enable sequences.
module tb_adc_scan_sequencer;

  localparam int unsigned SDIV = 100;
  localparam int unsigned NCH  = 3;
  localparam int unsigned DW   = 10;
  localparam int unsigned GW   = 4;
  localparam int unsigned TMO  = 64;

  logic          sysclk    = 1'b0;
  logic          reset_n   = 1'b0;
  logic          enable    = 1'b0;
  logic [GW-1:0] gain      = '0;
  logic          clr_flags = 1'b0;
  logic [DW-1:0] adc_data  = '0;
  logic          adc_valid = 1'b0;
  logic          adc_start;
  logic [2:0]    adc_channel;
  logic [DW-1:0] sample_out;
  logic [2:0]    sample_ch;
  logic          sample_valid;
  logic          scan_done;
  logic          overrun;
  logic          timeout_err;

  adc_scan_sequencer #(
    .SAMPLE_DIV (SDIV),
    .NCH        (NCH),
    .DW         (DW),
    .GW         (GW),
    .TIMEOUT    (TMO)
  ) dut (
    .sysclk       (sysclk),
    .reset_n      (reset_n),
    .enable       (enable),
    .gain         (gain),
    .clr_flags    (clr_flags),
    .adc_start    (adc_start),
    .adc_channel  (adc_channel),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .sample_out   (sample_out),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .scan_done    (scan_done),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]    ch;
    logic [DW-1:0] val;
    int            lat;
    int            t0;
  } exp_t;

  typedef struct {
    logic [GW-1:0] gain;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t          sb_q[$];
  logic [DW-1:0] adc_val [NCH];
  logic [DW-1:0] exp_val [NCH];
  bit            drop [NCH];
  int            lat = 20;
  bit            inj_valid = 1'b0;
  logic [2:0]    exp_ch = '0;
  bit            prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no event within bound, expected one (cycle %0d)", name, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_start"}, 32'(adc_start), 0);
    check({tag, "_adc_channel"}, 32'(adc_channel), 0);
    check({tag, "_sample_out"}, 32'(sample_out), 0);
    check({tag, "_sample_ch"}, 32'(sample_ch), 0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 0);
    check({tag, "_scan_done"}, 32'(scan_done), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic wait_done(output int t);
    bit seen = 1'b0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sysclk);
      if (scan_done) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!seen) fail_now("scan_done_wait");
  endtask

  task automatic wait_start(input logic [2:0] ch, output int t);
    bit seen = 1'b0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sysclk);
      if (adc_start && adc_channel == ch) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!seen) fail_now("adc_start_wait");
  endtask

  task automatic pulse_clr();
    @(negedge sysclk);
    clr_flags = 1'b1;
    @(negedge sysclk);
    clr_flags = 1'b0;
  endtask

  // spi2adc model: answers each start after 'lat' cycles unless the channel is set to drop.
  initial begin : adc_model
    bit         pend;
    int         cd;
    logic [2:0] mch;
    pend = 1'b0;
    cd   = 0;
    mch  = '0;
    forever begin
      @(negedge sysclk);
      adc_valid = inj_valid;
      adc_data  = 10'h3C3;
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cd == 0) begin
            pend = 1'b0;
            if (!drop[mch]) begin
              adc_valid = 1'b1;
              adc_data  = adc_val[mch];
            end
          end else begin
            cd--;
          end
        end
        if (adc_start) begin
          pend = 1'b1;
          cd   = lat - 1;
          mch  = adc_channel;
        end
      end
    end
  end

  // Scoreboard: expectation pushed at each start, popped on each emitted sample.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (!reset_n) begin
        prev_start = 1'b0;
      end else begin
        if (adc_start) begin
          check("start_width", 32'(prev_start), 0);
          check("start_ch", 32'(adc_channel), 32'(exp_ch));
          e.ch  = exp_ch;
          e.val = drop[exp_ch] ? '0 : exp_val[exp_ch];
          e.lat = drop[exp_ch] ? int'(TMO) + 2 : lat + 2;
          e.t0  = cyc;
          sb_q.push_back(e);
          exp_ch = (exp_ch == 3'(NCH - 1)) ? 3'd0 : exp_ch + 3'd1;
        end
        prev_start = adc_start;
        if (sample_valid) begin
          if (sb_q.size() == 0) begin
            fail_now("sample_expected");
          end else begin
            e = sb_q.pop_front();
            check("sample_ch", 32'(sample_ch), 32'(e.ch));
            check("sample_out", 32'(sample_out), 32'(e.val));
            check("scan_done_tag", 32'(scan_done), 32'(e.ch == 3'(NCH - 1)));
            check("latency", 32'(cyc - e.t0), 32'(e.lat));
          end
        end else if (scan_done) begin
          check("done_without_valid", 32'(scan_done), 0);
        end
      end
    end
  end

  initial begin : stim
    vec_t vecs [7];
    int   t1, t2, t3, t0, t_rel, sv, st;
    bit   got;

    vecs[0] = '{gain: 4'd15, data: 10'h3FF, exp: 10'h3FF};
    vecs[1] = '{gain: 4'd4,  data: 10'h201, exp: 10'h100};
    vecs[2] = '{gain: 4'd0,  data: 10'h2AB, exp: 10'h000};
    vecs[3] = '{gain: 4'd1,  data: 10'h3FF, exp: 10'h07F};
    vecs[4] = '{gain: 4'd12, data: 10'h2AA, exp: 10'h3FF};
    vecs[5] = '{gain: 4'd9,  data: 10'h100, exp: 10'h120};
    vecs[6] = '{gain: 4'd11, data: 10'h300, exp: 10'h3FF};

    adc_val[0] = 10'h155; adc_val[1] = 10'h0AA; adc_val[2] = 10'h2F0;
    for (int i = 0; i < int'(NCH); i++) begin
      exp_val[i] = adc_val[i];
      drop[i]    = 1'b0;
    end
    gain = 4'd8;

    repeat (3) @(negedge sysclk);
    check_all_zero("rst");
    reset_n = 1'b1;
    enable  = 1'b1;

    // Unity gain, steady scanning at the programmed rate.
    wait_done(t1);
    wait_done(t2);
    wait_done(t3);
    check("period_1", 32'(t2 - t1), SDIV);
    check("period_2", 32'(t3 - t2), SDIV);
    check("no_overrun", 32'(overrun), 0);
    check("no_timeout", 32'(timeout_err), 0);

    for (int v = 0; v < 7; v++) begin
      gain = vecs[v].gain;
      for (int c = 0; c < int'(NCH); c++) begin
        adc_val[c] = vecs[v].data;
        exp_val[c] = vecs[v].exp;
      end
      wait_done(t1);
    end

    gain = 4'd8;
    adc_val[0] = 10'h155; adc_val[1] = 10'h0AA; adc_val[2] = 10'h2F0;
    for (int i = 0; i < int'(NCH); i++) exp_val[i] = adc_val[i];

    // Channel 1 never answers.
    lat = 5;
    drop[1] = 1'b1;
    wait_done(t1);
    check("terr_set", 32'(timeout_err), 1);
    check("terr_no_overrun", 32'(overrun), 0);
    pulse_clr();
    check("terr_clr", 32'(timeout_err), 0);
    wait_start(3'd1, t0);
    repeat (TMO) @(negedge sysclk);
    clr_flags = 1'b1;
    @(negedge sysclk);
    clr_flags = 1'b0;
    check("terr_set_wins", 32'(timeout_err), 1);
    wait_done(t1);
    drop[1] = 1'b0;
    pulse_clr();
    check("terr_clr_2", 32'(timeout_err), 0);

    // Scan longer than the tick period.
    lat = 40;
    wait_done(t1);
    check("overrun_set", 32'(overrun), 1);
    lat = 20;
    wait_done(t1);
    check("overrun_sticky", 32'(overrun), 1);
    pulse_clr();
    check("overrun_clr", 32'(overrun), 0);

    // Asynchronous reset mid-cycle during channel 1 WAIT.
    wait_start(3'd1, t0);
    repeat (5) @(negedge sysclk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb_q.delete();
    exp_ch = '0;
    @(negedge sysclk);
    reset_n = 1'b1;
    t_rel = cyc;
    sv = 0;
    got = 1'b0;
    t1 = 0;
    for (int i = 0; i < int'(3 * SDIV); i++) begin
      @(negedge sysclk);
      if (sample_valid) sv++;
      if (adc_start) begin
        got = 1'b1;
        t1 = cyc;
        break;
      end
    end
    if (!got) fail_now("start_after_reset");
    else check("first_start_delay", 32'(t1 - t_rel), SDIV);
    check("no_sample_before_tick", 32'(sv), 0);

    // Enable dropped during ch0 WAIT: scan finishes, nothing further starts.
    @(negedge sysclk);
    enable = 1'b0;
    wait_done(t1);
    sv = 0;
    st = 0;
    for (int i = 0; i < int'(2 * SDIV + 20); i++) begin
      @(negedge sysclk);
      inj_valid = (i == 10);
      if (sample_valid) sv++;
      if (adc_start) st++;
    end
    check("idle_no_start", 32'(st), 0);
    check("idle_valid_ignored", 32'(sv), 0);
    check("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
